// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the RV32IM five-stage pipeline: load-use stall, EX redirect flush, MUL/DIV freeze with watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic             EX_MEM_READ,
    input  logic [4:0]       EX_RD,
    input  logic             EX_REDIRECT,
    input  logic             EX_MULDIV_START,
    input  logic             MULDIV_DONE,
    output logic             PC_WRITE_EN,
    output logic             IF_ID_WRITE_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_WRITE_EN,
    output logic             ID_EX_BUBBLE,
    output logic             EX_MEM_BUBBLE,
    output logic             MD_TIMEOUT_ERR,
    output logic [1:0]       HAZ_STATE,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic [CNT_W-1:0] FLUSH_COUNT
);
    // state      | meaning
    // ST_RUN     | normal issue; load-use stall and redirect flush handled here
    // ST_MD_WAIT | front of pipe frozen until MUL/DIV done or watchdog expiry

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01
    } state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;
    logic            load_use;
    logic            md_start;
    logic            md_timeout;

    assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    // A START that completes in the same cycle never leaves RUN.
    assign md_start   = (state == ST_RUN) && !EX_REDIRECT && EX_MULDIV_START && !MULDIV_DONE;
    assign md_timeout = (state == ST_MD_WAIT) && !MULDIV_DONE && (wd_cnt == WD_W'(MD_TIMEOUT));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_RUN;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_nxt    = wd_cnt;
        case (state)
            ST_RUN: begin
                if (md_start) begin
                    state_nxt = ST_MD_WAIT;
                    wd_nxt    = '0;
                end
            end
            ST_MD_WAIT: begin
                if (MULDIV_DONE || md_timeout) begin
                    state_nxt = ST_RUN;
                end else if (wd_cnt != WD_W'(MD_TIMEOUT)) begin
                    wd_nxt = wd_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        PC_WRITE_EN    = 1'b1;
        IF_ID_WRITE_EN = 1'b1;
        ID_EX_WRITE_EN = 1'b1;
        IF_ID_FLUSH    = 1'b0;
        ID_EX_BUBBLE   = 1'b0;
        EX_MEM_BUBBLE  = 1'b0;
        MD_TIMEOUT_ERR = 1'b0;
        if (!RST) begin
            PC_WRITE_EN    = 1'b0;
            IF_ID_WRITE_EN = 1'b0;
            ID_EX_WRITE_EN = 1'b0;
            IF_ID_FLUSH    = 1'b1;
            ID_EX_BUBBLE   = 1'b1;
            EX_MEM_BUBBLE  = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (EX_REDIRECT) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (md_start) begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        ID_EX_WRITE_EN = 1'b0;
                        EX_MEM_BUBBLE  = 1'b1;
                    end else if (load_use) begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        ID_EX_BUBBLE   = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (MULDIV_DONE) begin
                        MD_TIMEOUT_ERR = 1'b0;
                    end else if (md_timeout) begin
                        MD_TIMEOUT_ERR = 1'b1;
                    end else begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        ID_EX_WRITE_EN = 1'b0;
                        EX_MEM_BUBBLE  = 1'b1;
                    end
                end
                default: begin
                    PC_WRITE_EN = 1'b1;
                end
            endcase
        end
    end

    assign HAZ_STATE = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PC_WRITE_EN && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((state == ST_RUN) && EX_REDIRECT && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign STALL_CYCLES = stall_cnt;
    assign FLUSH_COUNT  = flush_cnt;
`else
    assign STALL_CYCLES = '0;
    assign FLUSH_COUNT  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a cycle model pushes expected outputs, the negedge sampler pops and compares.
module tb_pipeline_hazard_ctrl;
    localparam int MD_TIMEOUT = 40;
    localparam int CNT_W      = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [4:0]       ID_RS1, ID_RS2, EX_RD;
    logic             ID_USES_RS1, ID_USES_RS2, EX_MEM_READ;
    logic             EX_REDIRECT, EX_MULDIV_START, MULDIV_DONE;
    logic             PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_WRITE_EN;
    logic             ID_EX_BUBBLE, EX_MEM_BUBBLE, MD_TIMEOUT_ERR;
    logic [1:0]       HAZ_STATE;
    logic [CNT_W-1:0] STALL_CYCLES, FLUSH_COUNT;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_MEM_READ(EX_MEM_READ), .EX_RD(EX_RD),
        .EX_REDIRECT(EX_REDIRECT), .EX_MULDIV_START(EX_MULDIV_START), .MULDIV_DONE(MULDIV_DONE),
        .PC_WRITE_EN(PC_WRITE_EN), .IF_ID_WRITE_EN(IF_ID_WRITE_EN), .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_WRITE_EN(ID_EX_WRITE_EN), .ID_EX_BUBBLE(ID_EX_BUBBLE), .EX_MEM_BUBBLE(EX_MEM_BUBBLE),
        .MD_TIMEOUT_ERR(MD_TIMEOUT_ERR), .HAZ_STATE(HAZ_STATE),
        .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit          m_wait;
    int          m_wd;
    logic [31:0] m_stall, m_flush;

    bit tally_en;
    int t_idx, t_stall, t_err, t_err_at;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        ID_RS1 = 5'd0; ID_RS2 = 5'd0; EX_RD = 5'd0;
        ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0; EX_MEM_READ = 1'b0;
        EX_REDIRECT = 1'b0; EX_MULDIV_START = 1'b0; MULDIV_DONE = 1'b0;
    endtask

    // One clock cycle: model expectation, sample at negedge, advance model at posedge.
    task automatic step();
        exp_t       e;
        exp_t       got;
        logic       lu;
        logic [6:0] c;   // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, err}
        if (!RST) begin
            m_wait = 1'b0; m_wd = 0; m_stall = '0; m_flush = '0;
        end
        lu = EX_MEM_READ && (EX_RD != 5'd0) &&
             ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));
        if (!RST)                               c = 7'b0010110;
        else if (!m_wait) begin
            if (EX_REDIRECT)                    c = 7'b1111100;
            else if (EX_MULDIV_START && !MULDIV_DONE) c = 7'b0000010;
            else if (lu)                        c = 7'b0001100;
            else                                c = 7'b1101000;
        end else begin
            if (MULDIV_DONE)                    c = 7'b1101000;
            else if (m_wd == MD_TIMEOUT)        c = 7'b1101001;
            else                                c = 7'b0000010;
        end
        e.ctrl  = {c, (m_wait ? 2'b01 : 2'b00)};
        e.stall = PERF ? m_stall : 32'd0;
        e.flush = PERF ? m_flush : 32'd0;
        sb_q.push_back(e);

        @(negedge CLK);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            got.ctrl = {PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_WRITE_EN,
                        ID_EX_BUBBLE, EX_MEM_BUBBLE, MD_TIMEOUT_ERR, HAZ_STATE};
            chk("ctrl", 64'(got.ctrl), 64'(e.ctrl));
            chk("stall_cycles", 64'(STALL_CYCLES), 64'(e.stall));
            chk("flush_count", 64'(FLUSH_COUNT), 64'(e.flush));
        end
        if (tally_en) begin
            if (!PC_WRITE_EN) t_stall++;
            if (MD_TIMEOUT_ERR) begin
                t_err++;
                t_err_at = t_idx;
            end
            t_idx++;
        end

        @(posedge CLK);
        if (RST) begin
            if (!c[6]) m_stall++;
            if (!m_wait) begin
                if (EX_REDIRECT) m_flush++;
                else if (EX_MULDIV_START && !MULDIV_DONE) begin
                    m_wait = 1'b1;
                    m_wd   = 0;
                end
            end else if (MULDIV_DONE || (m_wd == MD_TIMEOUT)) begin
                m_wait = 1'b0;
            end else begin
                m_wd++;
            end
        end
        #1;
    endtask

    task automatic tally_start();
        tally_en = 1'b1; t_idx = 0; t_stall = 0; t_err = 0; t_err_at = -1;
    endtask

    logic [31:0] snap;

    initial begin
        RST = 1'b0;
        idle();
        tally_en = 1'b0;
        m_wait = 1'b0; m_wd = 0; m_stall = '0; m_flush = '0;
        step();
        step();
        RST = 1'b1;
        step();
        step();

        // load-use via rs2, then the load has left EX
        EX_MEM_READ = 1'b1; EX_RD = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1;
        tally_start();
        step();
        idle();
        step();
        tally_en = 1'b0;
        chk("lu_one_cycle", 64'(t_stall), 64'd1);
        // load-use via rs1; unused rs1 match; x0 destination
        EX_MEM_READ = 1'b1; EX_RD = 5'd7; ID_RS1 = 5'd7; ID_USES_RS1 = 1'b1;
        step();
        ID_USES_RS1 = 1'b0;
        step();
        EX_RD = 5'd0; ID_RS2 = 5'd0; ID_USES_RS2 = 1'b1; ID_RS1 = 5'd0; ID_USES_RS1 = 1'b1;
        step();
        idle();

        // redirect wins over load-use and MUL/DIV start
        snap = FLUSH_COUNT;
        EX_MEM_READ = 1'b1; EX_RD = 5'd9; ID_RS1 = 5'd9; ID_USES_RS1 = 1'b1;
        EX_REDIRECT = 1'b1; EX_MULDIV_START = 1'b1;
        step();
        idle();
        step();
        chk("flush_delta", 64'(FLUSH_COUNT - snap), PERF ? 64'd1 : 64'd0);

        // zero-wait MUL/DIV
        EX_MULDIV_START = 1'b1; MULDIV_DONE = 1'b1;
        tally_start();
        step();
        idle();
        step();
        tally_en = 1'b0;
        chk("zero_wait_stalls", 64'(t_stall), 64'd0);
        chk("zero_wait_state", 64'(HAZ_STATE), 64'd0);

        // MUL/DIV done 33 cycles after start; redirect/LU noise ignored while waiting
        snap = STALL_CYCLES;
        EX_MULDIV_START = 1'b1;
        tally_start();
        step();
        idle();
        for (int i = 1; i < 33; i++) begin
            if (i == 5) EX_REDIRECT = 1'b1;
            if (i == 6) begin
                EX_MEM_READ = 1'b1; EX_RD = 5'd3; ID_RS2 = 5'd3; ID_USES_RS2 = 1'b1;
            end
            if (i == 7) EX_MULDIV_START = 1'b1;
            step();
            idle();
        end
        MULDIV_DONE = 1'b1;
        step();
        idle();
        tally_en = 1'b0;
        chk("md33_stalls", 64'(t_stall), 64'd33);
        chk("md33_stall_cnt", 64'(STALL_CYCLES - snap), PERF ? 64'd33 : 64'd0);
        chk("md33_state", 64'(HAZ_STATE), 64'd0);
        step();

        // watchdog timeout
        EX_MULDIV_START = 1'b1;
        tally_start();
        step();
        idle();
        for (int i = 1; i <= MD_TIMEOUT + 1; i++) step();
        step();
        tally_en = 1'b0;
        chk("to_stalls", 64'(t_stall), 64'(MD_TIMEOUT + 1));
        chk("to_err_pulses", 64'(t_err), 64'd1);
        chk("to_err_cycle", 64'(t_err_at), 64'(MD_TIMEOUT + 1));

        // reset during cycle 10 of MD_WAIT
        EX_MULDIV_START = 1'b1;
        step();
        idle();
        for (int i = 1; i < 10; i++) step();
        RST = 1'b0;
        step();
        chk("rst_state", 64'(HAZ_STATE), 64'd0);
        chk("rst_stall_cnt", 64'(STALL_CYCLES), 64'd0);
        RST = 1'b1;
        step();
        EX_MEM_READ = 1'b1; EX_RD = 5'd12; ID_RS2 = 5'd12; ID_USES_RS2 = 1'b1;
        step();
        idle();
        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the RV32IM five-stage pipeline. It sits beside the decode stage and drives the PC, IF/ID, ID/EX and EX/MEM pipeline-register enables, flushes and bubbles. It resolves three cases:
- load-use hazards, with a one-cycle stall;
- control redirects from EX (taken branch or jump), with a flush;
- multi-cycle MUL/DIV operations, which freeze the front of the pipeline until completion, guarded by a timeout watchdog.

## Interface
- MD_TIMEOUT, 40: maximum MD_WAIT cycles before the watchdog aborts (must be ≥ 2).
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- ID_RS1  in  5  rs1 field of instruction in ID.
- ID_RS2  in  5  rs2 field of instruction in ID.
- ID_USES_RS1  in  1  ID instruction reads rs1.
- ID_USES_RS2  in  1  ID instruction reads rs2.
- EX_MEM_READ  in  1  instruction in EX is a load.
- EX_RD  in  5  destination register of instruction in EX.
- EX_REDIRECT  in  1  EX resolved a taken branch or jump this cycle.
- EX_MULDIV_START  in  1  multi-cycle MUL/DIV entered EX this cycle (single-cycle pulse).
- MULDIV_DONE  in  1  MUL/DIV unit result valid.
- PC_WRITE_EN  out  1  PC register update enable.
- IF_ID_WRITE_EN  out  1  IF/ID register enable.
- IF_ID_FLUSH  out  1  load NOP into IF/ID.
- ID_EX_WRITE_EN  out  1  ID/EX register enable.
- ID_EX_BUBBLE  out  1  load NOP controls into ID/EX.
- EX_MEM_BUBBLE  out  1  load NOP controls into EX/MEM.
- MD_TIMEOUT_ERR  out  1  one-cycle pulse on watchdog abort.
- HAZ_STATE  out  2  current FSM state (RUN=00, MD_WAIT=01).
- STALL_CYCLES  out  CNT_W  stall-cycle counter (see Configuration).
- FLUSH_COUNT  out  CNT_W  redirect counter (see Configuration).

## Operation
- FSM with two states, RUN and MD_WAIT. Registers: state, watchdog counter of width $clog2(MD_TIMEOUT+1), and perf counters.
- Outputs are combinational from state and inputs; the FSM and counters are registered.
- Load-use hazard (LU) = EX_MEM_READ & EX_RD≠0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- RUN priority:
  - EX_REDIRECT asserted: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, all enables 1. Redirect wins over LU and over EX_MULDIV_START.
  - Else EX_MULDIV_START=1 & MULDIV_DONE=0: go to MD_WAIT, clear the watchdog. Outputs this cycle are the MD_WAIT outputs.
  - Else LU: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1, ID_EX_WRITE_EN=1.
  - Else: all enables 1, all flush/bubble 0.
- EX_MULDIV_START with MULDIV_DONE in the same cycle is a zero-wait op: no stall, stay in RUN.
- MD_WAIT outputs: PC_WRITE_EN=IF_ID_WRITE_EN=ID_EX_WRITE_EN=0, EX_MEM_BUBBLE=1. EX_REDIRECT, LU and EX_MULDIV_START are ignored.
- MD_WAIT exit:
  - MULDIV_DONE=1: enables all 1 and EX_MEM_BUBBLE=0 in that cycle; next state RUN.
  - Watchdog reaches MD_TIMEOUT with no DONE: pulse MD_TIMEOUT_ERR, release the enables as for DONE, return to RUN.
- Watchdog increments each MD_WAIT cycle and saturates. It is cleared on entry to MD_WAIT.

## Timing
- Reset (RST=0, asynchronous):
  - state=RUN, watchdog=0, counters=0.
  - While RST is low, outputs are forced: PC/IF_ID/ID_EX write enables=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, EX_MEM_BUBBLE=1, MD_TIMEOUT_ERR=0, HAZ_STATE=00.
- Reset asserted during MD_WAIT returns immediately to RUN; the pending op is abandoned.
- Zero-cycle latency from inputs to control outputs.
- A load-use stall lasts exactly one cycle, because the load leaves EX.
- A MUL/DIV that asserts DONE N cycles after START produces N stall cycles (1 ≤ N ≤ MD_TIMEOUT).
- A timeout produces MD_TIMEOUT+1 stall cycles, then the MD_TIMEOUT_ERR pulse on the release cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - STALL_CYCLES increments each cycle with PC_WRITE_EN=0 outside reset.
  - FLUSH_COUNT increments on each accepted redirect in RUN.
  - Both saturate at 2^CNT_W−1.
- HAZARD_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 → PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1 for one cycle. Repeat with EX_RD=0 → no stall.
- Redirect: EX_REDIRECT=1 together with LU=1 → IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE_EN=1; FLUSH_COUNT +1 (with macro).
- MUL/DIV: START pulse, DONE after 33 cycles → 33 cycles of HAZ_STATE=01 with enables 0, then RUN; STALL_CYCLES=33.
- Zero-wait: START and DONE in the same cycle → no stall, HAZ_STATE stays 00.
- Timeout: START, DONE never → MD_TIMEOUT_ERR pulses once after 41 cycles (MD_TIMEOUT=40), then enables return to 1.
- Reset: RST low during cycle 10 of MD_WAIT → immediate RUN, forced reset outputs, counters 0. After release, normal RUN outputs.
